dispatch_queue: RTL and testbench

//  In-order dispatch buffer between the instruction decoder and the execution units.

---
 rtl/dispatch_queue.sv | 125 ++++++++++++
 tb/tb_dispatch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// In-order dispatch buffer: queues decoded instructions with a sequence tag and
// offers the oldest entry to exactly one execution unit (ALU, LSU or MULDIV).
module dispatch_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     inst_valid_i,
   output logic                     inst_ready_o,
   input  logic [31:0]              inst_i,
   input  logic [31:0]              pc_i,
   input  logic                     alu_i,
   input  logic                     lsu_i,
   input  logic                     muldiv_i,
   input  logic                     br_i,
   input  logic                     flush_i,
   output logic                     alu_valid_o,
   input  logic                     alu_ready_i,
   output logic                     lsu_valid_o,
   input  logic                     lsu_ready_i,
   output logic                     muldiv_valid_o,
   input  logic                     muldiv_ready_i,
   output logic [31:0]              disp_inst_o,
   output logic [31:0]              disp_pc_o,
   output logic [TAG_W-1:0]         disp_tag_o,
   output logic                     illegal_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [1:0] UNIT_ALU    = 2'd0;
   localparam logic [1:0] UNIT_LSU    = 2'd1;
   localparam logic [1:0] UNIT_MULDIV = 2'd2;

   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic [1:0]       unit_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem  [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [TAG_W-1:0] tag_cnt;
   logic             illegal;

   logic       has_class;
   logic       accept;
   logic       push;
   logic       pop;
   logic       head_valid;
   logic [1:0] in_unit;
   logic [1:0] head_unit;

   // Multi-hot class vectors are malformed; LSU wins, then MULDIV, else ALU.
   always_comb begin
      in_unit = UNIT_ALU;
      if (lsu_i)
         in_unit = UNIT_LSU;
      else if (muldiv_i)
         in_unit = UNIT_MULDIV;
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid and the head payload stay stable until that transfer, and
   // inst_ready_o depends only on occupancy, never on same-cycle dispatch.
   assign has_class    = alu_i | lsu_i | muldiv_i | br_i;
   assign inst_ready_o = (count < FULL_COUNT);
   assign accept       = inst_valid_i && inst_ready_o;
   assign push         = accept && has_class;

   assign head_valid     = (count != '0);
   assign head_unit      = unit_mem[rd_ptr];
   assign alu_valid_o    = head_valid && (head_unit == UNIT_ALU);
   assign lsu_valid_o    = head_valid && (head_unit == UNIT_LSU);
   assign muldiv_valid_o = head_valid && (head_unit == UNIT_MULDIV);
   assign pop = (alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i) ||
                (muldiv_valid_o && muldiv_ready_i);

   assign disp_inst_o = head_valid ? inst_mem[rd_ptr] : '0;
   assign disp_pc_o   = head_valid ? pc_mem[rd_ptr]   : '0;
   assign disp_tag_o  = head_valid ? tag_mem[rd_ptr]  : '0;
   assign illegal_o   = illegal;
   assign count_o     = count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         tag_cnt <= '0;
         illegal <= 1'b0;
      end else if (flush_i) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         illegal <= 1'b0;
      end else begin
         illegal <= accept && !has_class;
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            tag_cnt <= tag_cnt + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push) begin
         inst_mem[wr_ptr] <= inst_i;
         pc_mem[wr_ptr]   <= pc_i;
         unit_mem[wr_ptr] <= in_unit;
         tag_mem[wr_ptr]  <= tag_cnt;
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer.
module tb_dispatch_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic        clk;
   logic        rst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        alu, lsu, muldiv, br;
   logic        flush;
   logic        alu_valid, alu_ready;
   logic        lsu_valid, lsu_ready;
   logic        muldiv_valid, muldiv_ready;
   logic [31:0] disp_inst;
   logic [31:0] disp_pc;
   logic [TAG_W-1:0] disp_tag;
   logic        illegal;
   logic [2:0]  count;

   dispatch_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
      .inst_i(inst), .pc_i(pc),
      .alu_i(alu), .lsu_i(lsu), .muldiv_i(muldiv), .br_i(br),
      .flush_i(flush),
      .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
      .lsu_valid_o(lsu_valid), .lsu_ready_i(lsu_ready),
      .muldiv_valid_o(muldiv_valid), .muldiv_ready_i(muldiv_ready),
      .disp_inst_o(disp_inst), .disp_pc_o(disp_pc), .disp_tag_o(disp_tag),
      .illegal_o(illegal), .count_o(count)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model entry: unit 0=ALU 1=LSU 2=MULDIV
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  unit;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t            exp_q[$];
   logic [TAG_W-1:0]  got_tags[$];
   int                model_tag;
   logic              model_illegal;
   bit                started;
   int                checks;
   int                failures;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor + reference model: compares DUT state, then applies the inputs
   // that the next rising edge will sample
   always @(negedge clk) begin
      int n;
      logic [3:0] cls;
      logic [1:0] u;
      logic acc;
      logic pop_ok;
      if (started) begin
         n = exp_q.size();
         check("count", 64'(count), 64'(n));
         check("inst_ready", 64'(inst_ready), 64'(n < DEPTH));
         check("alu_valid", 64'(alu_valid), 64'(n > 0 && exp_q[0].unit == 2'd0));
         check("lsu_valid", 64'(lsu_valid), 64'(n > 0 && exp_q[0].unit == 2'd1));
         check("muldiv_valid", 64'(muldiv_valid), 64'(n > 0 && exp_q[0].unit == 2'd2));
         check("disp_inst", 64'(disp_inst), n > 0 ? 64'(exp_q[0].inst) : 64'd0);
         check("disp_pc", 64'(disp_pc), n > 0 ? 64'(exp_q[0].pc) : 64'd0);
         check("disp_tag", 64'(disp_tag), n > 0 ? 64'(exp_q[0].tag) : 64'd0);
         check("illegal", 64'(illegal), 64'(model_illegal));
      end
      if (rst) begin
         exp_q.delete();
         model_tag = 0;
         model_illegal = 1'b0;
         started = 1'b1;
      end else if (started) begin
         if (flush) begin
            exp_q.delete();
            model_illegal = 1'b0;
         end else begin
            n = exp_q.size();
            cls = {br, muldiv, lsu, alu};
            acc = inst_valid && (n < DEPTH);
            pop_ok = 1'b0;
            if (n > 0) begin
               case (exp_q[0].unit)
                  2'd0:    pop_ok = alu_ready;
                  2'd1:    pop_ok = lsu_ready;
                  default: pop_ok = muldiv_ready;
               endcase
            end
            if (pop_ok) begin
               got_tags.push_back(disp_tag);
               void'(exp_q.pop_front());
            end
            if (acc && cls != 4'd0) begin
               u = lsu ? 2'd1 : (muldiv ? 2'd2 : 2'd0);
               exp_q.push_back('{inst: inst, pc: pc, unit: u, tag: TAG_W'(model_tag)});
               model_tag = (model_tag + 1) % (1 << TAG_W);
            end
            model_illegal = acc && (cls == 4'd0);
         end
      end
   end

   // driver tasks
   task automatic cyc(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] cls, input logic [31:0] i, input logic [31:0] p);
      inst_valid = v;
      {br, muldiv, lsu, alu} = cls;
      inst = i;
      pc = p;
   endtask

   task automatic readies(input logic a, input logic l, input logic m);
      alu_ready = a;
      lsu_ready = l;
      muldiv_ready = m;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      readies(1'b0, 1'b0, 1'b0);
      flush = 1'b0;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      started = 1'b0;
      model_tag = 0;
      model_illegal = 1'b0;
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      readies(1'b0, 1'b0, 1'b0);

      // 1: single ALU instruction
      do_reset();
      got_tags.delete();
      drive(1'b1, 4'b0001, 32'h0050_0093, 32'h0);
      cyc();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      cyc();
      readies(1'b1, 1'b0, 1'b0);
      cyc();
      readies(1'b0, 1'b0, 1'b0);
      cyc();
      check("t1_ndisp", 64'(got_tags.size()), 64'd1);
      if (got_tags.size() > 0) check("t1_tag", 64'(got_tags[0]), 64'd0);

      // 2: stalled LSU head blocks younger ALU/MULDIV entries
      do_reset();
      got_tags.delete();
      drive(1'b1, 4'b0010, 32'h0000_a003, 32'h100);
      cyc();
      drive(1'b1, 4'b0001, 32'h0000_0013, 32'h104);
      cyc();
      drive(1'b1, 4'b0100, 32'h0200_0033, 32'h108);
      cyc();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      readies(1'b1, 1'b0, 1'b1);
      cyc(3);
      check("t2_blocked", 64'(got_tags.size()), 64'd0);
      readies(1'b1, 1'b1, 1'b1);
      cyc(4);
      readies(1'b0, 1'b0, 1'b0);
      check("t2_ndisp", 64'(got_tags.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_tags.size(); i++)
         check("t2_order", 64'(got_tags[i]), 64'(i));

      // 3: fill, then one dispatch while the 5th is waiting
      do_reset();
      drive(1'b1, 4'b0001, 32'h1111_0000, 32'h200);
      cyc(5);
      readies(1'b1, 1'b0, 1'b0);
      cyc();
      readies(1'b0, 1'b0, 1'b0);
      cyc(2);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      cyc();

      // 4: instruction with no class bits
      do_reset();
      drive(1'b1, 4'b0000, 32'hdead_beef, 32'h300);
      cyc();
      drive(1'b1, 4'b1000, 32'h0000_0063, 32'h304);
      cyc();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      readies(1'b1, 1'b0, 1'b0);
      cyc(2);

      // 5: 18 back-to-back push/pop pairs, tag wrap
      do_reset();
      got_tags.delete();
      readies(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 4'b0001 << (i % 3), 32'h4000 + 32'(i), 32'h400 + 32'(4 * i));
         cyc();
      end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      cyc(2);
      check("t5_ndisp", 64'(got_tags.size()), 64'd18);
      for (int i = 0; i < 18 && i < got_tags.size(); i++)
         check("t5_tag", 64'(got_tags[i]), 64'(i % 16));
      readies(1'b0, 1'b0, 1'b0);

      // 6: flush with a same-cycle push and dispatch handshake
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'b0001, 32'h5000 + 32'(i), 32'h500 + 32'(4 * i));
         cyc();
      end
      flush = 1'b1;
      readies(1'b1, 1'b0, 1'b0);
      drive(1'b1, 4'b0001, 32'h5555_5555, 32'h50c);
      cyc();
      flush = 1'b0;
      readies(1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'b0010, 32'h6666_6666, 32'h510);
      cyc();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      cyc();
      check("t6_tag_after_flush", 64'(disp_tag), 64'd3);

      // random traffic
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom, $urandom);
         readies($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         flush = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      readies(1'b1, 1'b1, 1'b1);
      cyc(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
